// File: rtl/mem_stage_dcache.sv
// rtl/mem_stage_dcache.sv - direct-mapped write-back write-allocate MEM-stage data cache with line miss FSM
// Optional macro DCACHE_PERF_COUNTERS_EN adds out_hit_count / out_miss_count.
module mem_stage_dcache #(
   parameter int NUM_LINES  = 4,
   parameter int LINE_BYTES = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  in_addr,
   input  logic [31:0]  in_mem_data,
   input  logic         in_mem_read,
   input  logic         in_mem_write,
   input  logic [2:0]   in_funct3,
   input  logic [3:0]   in_rob_idx,
   output logic         out_d_cache_stall,
   output logic [31:0]  out_read_data,
   output logic         out_complete,
   output logic [3:0]   out_complete_idx,
   output logic         out_misaligned,
   output logic         out_mem_req,
   output logic         out_mem_we,
   output logic [31:0]  out_mem_addr,
   output logic [127:0] out_mem_wdata,
   input  logic         in_mem_ready,
   input  logic [127:0] in_mem_rdata
`ifdef DCACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]  out_hit_count,
   output logic [31:0]  out_miss_count
`else
`endif
);

   localparam int OFF_W     = $clog2(LINE_BYTES);
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = 32 - OFF_W - IDX_W;
   localparam int LINE_BITS = LINE_BYTES * 8;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

   state_t                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [NUM_LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [TAG_W-1:0]       tag_d  [NUM_LINES];
   logic [LINE_BITS-1:0]   data_q [NUM_LINES];
   logic [LINE_BITS-1:0]   data_d [NUM_LINES];
   logic                   complete_q, complete_d;
   logic                   misaligned_q, misaligned_d;
   logic [3:0]             complete_idx_q, complete_idx_d;
   logic [31:0]            read_data_q, read_data_d;

   logic [IDX_W-1:0]       idx;
   logic [TAG_W-1:0]       tag;
   logic [OFF_W-1:0]       off;
   logic                   access, misaligned, hit, miss;
   logic [LINE_BITS-1:0]   cur_line, shifted, wmask, wval, merged;
   logic [31:0]            raw, load_ext;

   assign idx        = in_addr[OFF_W +: IDX_W];
   assign tag        = in_addr[31 -: TAG_W];
   assign off        = in_addr[OFF_W-1:0];
   assign access     = in_mem_read | in_mem_write;
   assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                       ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
   assign hit        = valid_q[idx] && (tag_q[idx] == tag);
   assign miss       = access && !misaligned && !hit;

   assign cur_line = data_q[idx];
   assign shifted  = cur_line >> {off, 3'b000};
   assign raw      = shifted[31:0];

   always_comb begin
      load_ext = raw;
      case (in_funct3)
         3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
         3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
         3'b100:  load_ext = {24'b0, raw[7:0]};
         3'b101:  load_ext = {16'b0, raw[15:0]};
         default: load_ext = raw;
      endcase
   end

   // Byte-lane merge of the store into the resident line.
   always_comb begin
      wmask = '0;
      case (in_funct3[1:0])
         2'b00:   wmask[7:0]  = 8'hff;
         2'b01:   wmask[15:0] = 16'hffff;
         default: wmask[31:0] = 32'hffff_ffff;
      endcase
      wmask  = wmask << {off, 3'b000};
      wval   = {{(LINE_BITS-32){1'b0}}, in_mem_data} << {off, 3'b000};
      merged = (cur_line & ~wmask) | (wval & wmask);
   end

   assign out_d_cache_stall = (access && (state_q == S_IDLE) && miss) || (state_q != S_IDLE);

   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      dirty_d        = dirty_q;
      tag_d          = tag_q;
      data_d         = data_q;
      complete_d     = 1'b0;
      misaligned_d   = 1'b0;
      complete_idx_d = 4'd0;
      read_data_d    = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (misaligned) begin
                  complete_d     = 1'b1;
                  misaligned_d   = 1'b1;
                  complete_idx_d = in_rob_idx;
               end else if (hit) begin
                  complete_d     = 1'b1;
                  complete_idx_d = in_rob_idx;
                  if (in_mem_read) begin
                     read_data_d = load_ext;
                  end else begin
                     data_d[idx]  = merged;
                     dirty_d[idx] = 1'b1;
                  end
               end else begin
                  state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
               end
            end
         end
         S_WRITEBACK: begin
            if (in_mem_ready) state_d = S_REFILL;
         end
         S_REFILL: begin
            // The stalled access replays as a hit once the fill lands.
            if (in_mem_ready) begin
               data_d[idx]  = in_mem_rdata;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               tag_d[idx]   = tag;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_mem_req   = 1'b0;
      out_mem_we    = 1'b0;
      out_mem_addr  = 32'd0;
      out_mem_wdata = '0;
      case (state_q)
         S_WRITEBACK: begin
            out_mem_req   = 1'b1;
            out_mem_we    = 1'b1;
            out_mem_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
            out_mem_wdata = data_q[idx];
         end
         S_REFILL: begin
            out_mem_req  = 1'b1;
            out_mem_addr = {in_addr[31:OFF_W], {OFF_W{1'b0}}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         valid_q        <= '0;
         dirty_q        <= '0;
         complete_q     <= 1'b0;
         misaligned_q   <= 1'b0;
         complete_idx_q <= 4'd0;
         read_data_q    <= 32'd0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         dirty_q        <= dirty_d;
         complete_q     <= complete_d;
         misaligned_q   <= misaligned_d;
         complete_idx_q <= complete_idx_d;
         read_data_q    <= read_data_d;
      end
   end

   // Tag and data storage need no reset: valid gates every use.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign out_complete     = complete_q;
   assign out_misaligned   = misaligned_q;
   assign out_complete_idx = complete_idx_q;
   assign out_read_data    = read_data_q;

`ifdef DCACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        after_miss_q, after_miss_d;

   // The replay hit that follows a miss is not a separate hit.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      after_miss_d = after_miss_q;
      if ((state_q == S_IDLE) && access && !misaligned) begin
         if (hit) begin
            if (after_miss_q) after_miss_d = 1'b0;
            else              hit_count_d  = hit_count_q + 32'd1;
         end else begin
            miss_count_d = miss_count_q + 32'd1;
            after_miss_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
         after_miss_q <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         after_miss_q <= after_miss_d;
      end
   end

   assign out_hit_count  = hit_count_q;
   assign out_miss_count = miss_count_q;
`else
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb/tb_mem_stage_dcache.sv - self-checking bench for mem_stage_dcache against a byte-memory/residency model
module tb_mem_stage_dcache;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  in_addr, in_mem_data;
   logic         in_mem_read, in_mem_write;
   logic [2:0]   in_funct3;
   logic [3:0]   in_rob_idx;
   logic         out_d_cache_stall, out_complete, out_misaligned;
   logic [31:0]  out_read_data, out_mem_addr;
   logic [3:0]   out_complete_idx;
   logic         out_mem_req, out_mem_we, in_mem_ready;
   logic [127:0] out_mem_wdata, in_mem_rdata;
`ifdef DCACHE_PERF_COUNTERS_EN
   logic [31:0]  hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   mem_stage_dcache #(.NUM_LINES(4), .LINE_BYTES(16)) dut (
      .clk(clk), .reset(reset), .in_addr(in_addr), .in_mem_data(in_mem_data),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
      .in_rob_idx(in_rob_idx), .out_d_cache_stall(out_d_cache_stall),
      .out_read_data(out_read_data), .out_complete(out_complete),
      .out_complete_idx(out_complete_idx), .out_misaligned(out_misaligned),
      .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
      .out_mem_wdata(out_mem_wdata), .in_mem_ready(in_mem_ready), .in_mem_rdata(in_mem_rdata)
`ifdef DCACHE_PERF_COUNTERS_EN
      , .out_hit_count(hit_count), .out_miss_count(miss_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Architectural memory: every byte's current value; cache residency kept per index.
   logic [7:0]  ov [int unsigned];
   bit          rv [4];
   bit          dy [4];
   int unsigned rt [4];

   function automatic logic [7:0] mem_byte(input int unsigned a);
      if (ov.exists(a)) return ov[a];
      return 8'(a * 7 + 3);
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      logic [127:0] l;
      logic [31:0]  base;
      base = a & ~32'hF;
      for (int i = 0; i < 16; i++) l[i*8 +: 8] = mem_byte(base + 32'(i));
      return l;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] w;
      w = {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
      case (f3)
         3'b000:  return 32'($signed(w[7:0]));
         3'b001:  return 32'($signed(w[15:0]));
         3'b100:  return {24'b0, w[7:0]};
         3'b101:  return {16'b0, w[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic store_bytes(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      int n;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) ov[a + 32'(i)] = d[i*8 +: 8];
   endtask

   logic         chk_en = 1'b0;
   logic         exp_stall, exp_req, exp_we, exp_complete, exp_mis;
   logic [31:0]  exp_addr, exp_rdata;
   logic [127:0] exp_wdata;
   logic [3:0]   exp_cidx;
   logic         pv, pmis;
   logic [3:0]   pidx;
   logic [31:0]  pdata;

   int           stall_cnt = 0, complete_cnt = 0;
   logic [31:0]  last_data, wb_addr_seen;
   logic [3:0]   last_idx;
   logic         last_mis;
   logic [31:0]  wb_word0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", out_d_cache_stall, exp_stall);
         check("mem_req", out_mem_req, exp_req);
         if (exp_req) begin
            check("mem_we", out_mem_we, exp_we);
            check("mem_addr", out_mem_addr, exp_addr);
            if (exp_we) check("mem_wdata", out_mem_wdata, exp_wdata);
         end
         check("complete", out_complete, exp_complete);
         check("complete_idx", out_complete_idx, exp_cidx);
         check("read_data", out_read_data, exp_rdata);
         check("misaligned", out_misaligned, exp_mis);
         if (out_d_cache_stall) stall_cnt++;
         if (out_complete) begin
            complete_cnt++;
            last_data = out_read_data;
            last_idx  = out_complete_idx;
            last_mis  = out_misaligned;
         end
         if (out_mem_req && out_mem_we) begin
            wb_addr_seen = out_mem_addr;
            wb_word0     = out_mem_wdata[31:0];
         end
      end
   end

   // One cycle: publish this cycle's expectations, queue what completes next cycle.
   task automatic step(input bit done_now, input logic [3:0] ci, input logic [31:0] cd, input bit cm);
      exp_complete = pv;
      exp_cidx     = pidx;
      exp_rdata    = pdata;
      exp_mis      = pmis;
      pv    = done_now;
      pidx  = done_now ? ci : 4'd0;
      pdata = done_now ? cd : 32'd0;
      pmis  = done_now ? cm : 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_mem_read  = 1'b0;
      in_mem_write = 1'b0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = '0;
      repeat (n) step(1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic [3:0] ri, input int lat);
      bit          mis, hit;
      int          ix;
      int unsigned tg;
      logic [31:0] res;
      mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
      ix  = int'(a[5:4]);
      tg  = a >> 6;
      hit = rv[ix] && (rt[ix] == tg);
      in_mem_read = rd; in_mem_write = wr; in_addr = a; in_mem_data = d;
      in_funct3 = f3; in_rob_idx = ri;
      exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = '0;
      if (!mis && !hit) begin
         exp_stall = 1'b1;
         step(1'b0, 4'd0, 32'd0, 1'b0);
         if (rv[ix] && dy[ix]) begin
            exp_req   = 1'b1;
            exp_we    = 1'b1;
            exp_addr  = 32'((rt[ix] << 6) | (32'(ix) << 4));
            exp_wdata = mem_line(exp_addr);
            for (int k = 0; k < lat; k++) begin
               in_mem_ready = (k == lat - 1);
               step(1'b0, 4'd0, 32'd0, 1'b0);
            end
         end
         exp_req = 1'b1; exp_we = 1'b0; exp_addr = a & ~32'hF; exp_wdata = '0;
         for (int k = 0; k < lat; k++) begin
            in_mem_ready = (k == lat - 1);
            in_mem_rdata = (k == lat - 1) ? mem_line(a) : {4{$urandom}};
            step(1'b0, 4'd0, 32'd0, 1'b0);
         end
         rv[ix] = 1'b1; rt[ix] = tg; dy[ix] = 1'b0;
         in_mem_ready = 1'b0;
         exp_req = 1'b0; exp_addr = 32'd0;
      end
      exp_stall = 1'b0;
      res = (mis || !rd) ? 32'd0 : load_val(a, f3);
      step(1'b1, ri, res, mis);
      if (wr && !mis) begin
         store_bytes(a, d, f3);
         dy[ix] = 1'b1;
      end
      in_mem_read  = 1'b0;
      in_mem_write = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         rv[i] = 1'b0; dy[i] = 1'b0; rt[i] = 0;
      end
      pv = 1'b0; pidx = 4'd0; pdata = 32'd0; pmis = 1'b0;
   endtask

   initial begin
      int cc;
      reset = 1'b0; in_addr = 32'd0; in_mem_data = 32'd0; in_mem_read = 1'b0;
      in_mem_write = 1'b0; in_funct3 = 3'd0; in_rob_idx = 4'd0;
      in_mem_ready = 1'b0; in_mem_rdata = '0;
      last_data = 32'd0; last_idx = 4'd0; last_mis = 1'b0; wb_addr_seen = 32'd0; wb_word0 = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", out_d_cache_stall, 1'b0);
      check("rst_mem_req", out_mem_req, 1'b0);
      check("rst_complete", out_complete, 1'b0);
      check("rst_read_data", out_read_data, 32'd0);
      check("rst_misaligned", out_misaligned, 1'b0);
      reset  = 1'b1;
      chk_en = 1'b1;

      ov[32'h100] = 8'hEF; ov[32'h101] = 8'hBE; ov[32'h102] = 8'hAD; ov[32'h103] = 8'hDE;

      // Clean miss, memory answers on the third REFILL cycle.
      stall_cnt = 0;
      access(1, 0, 32'h100, 32'd0, 3'b010, 4'h5, 3);
      idle(1);
      check("t1_stall_cycles", 32'(stall_cnt), 32'd4);
      check("t1_data", last_data, 32'hDEADBEEF);
      check("t1_rob_idx", last_idx, 4'h5);

      // Resident-line byte store, signed and unsigned byte loads.
      stall_cnt = 0;
      access(0, 1, 32'h101, 32'h80, 3'b000, 4'h1, 3);
      access(1, 0, 32'h101, 32'd0, 3'b000, 4'h2, 3);
      idle(1);
      check("t2_lb", last_data, 32'hFFFFFF80);
      access(1, 0, 32'h101, 32'd0, 3'b100, 4'h3, 3);
      idle(1);
      check("t2_lbu", last_data, 32'h00000080);
      access(0, 1, 32'h104, 32'h12345678, 3'b010, 4'h4, 3);
      access(1, 0, 32'h106, 32'd0, 3'b001, 4'h5, 3);
      access(0, 1, 32'h10E, 32'h00008001, 3'b001, 4'h6, 3);
      access(1, 0, 32'h10E, 32'd0, 3'b001, 4'h7, 3);
      access(1, 0, 32'h10E, 32'd0, 3'b101, 4'h8, 3);
      idle(1);
      check("t2_lhu", last_data, 32'h00008001);
      check("t2_no_stall", 32'(stall_cnt), 32'd0);

      // Dirty victim: store then conflicting load at the same index.
      access(0, 1, 32'h100, 32'hCAFEF00D, 3'b010, 4'h6, 2);
      cc = complete_cnt;
      access(1, 0, 32'h140, 32'd0, 3'b010, 4'h7, 2);
      idle(2);
      check("t3_wb_addr", wb_addr_seen, 32'h100);
      check("t3_wb_word0", wb_word0, 32'hCAFEF00D);
      check("t3_single_complete", 32'(complete_cnt - cc), 32'd2);

      // Misaligned accesses never touch the cache or memory.
      access(1, 0, 32'h102, 32'd0, 3'b010, 4'h8, 2);
      idle(1);
      check("t4_misaligned", last_mis, 1'b1);
      check("t4_data", last_data, 32'd0);
      access(0, 1, 32'h141, 32'hFFFF, 3'b001, 4'h9, 2);
      access(1, 0, 32'h1F0, 32'd0, 3'b010, 4'hA, 1);
      access(1, 0, 32'h141, 32'd0, 3'b101, 4'hB, 1);
      idle(1);

      // Reset in the middle of a REFILL; late ready must be ignored.
      in_mem_read = 1'b1; in_addr = 32'h100; in_funct3 = 3'b010; in_rob_idx = 4'h9;
      exp_stall = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0;
      step(1'b0, 4'd0, 32'd0, 1'b0);
      exp_req = 1'b1; exp_addr = 32'h100;
      step(1'b0, 4'd0, 32'd0, 1'b0);
      reset = 1'b0;
      step(1'b0, 4'd0, 32'd0, 1'b0);
      reset = 1'b1; in_mem_read = 1'b0;
      in_mem_ready = 1'b1; in_mem_rdata = {4{32'h0BAD0BAD}};
      exp_stall = 1'b0; exp_req = 1'b0; exp_addr = 32'd0;
      step(1'b0, 4'd0, 32'd0, 1'b0);
      in_mem_ready = 1'b0;
      model_reset();
      stall_cnt = 0;
      access(1, 0, 32'h100, 32'd0, 3'b010, 4'hC, 2);
      idle(1);
      check("t5_miss_again", 32'(stall_cnt), 32'd3);
      check("t5_data", last_data, 32'hCAFEF00D);

`ifdef DCACHE_PERF_COUNTERS_EN
      chk_en = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      chk_en = 1'b1;
      access(1, 0, 32'h100, 32'd0, 3'b010, 4'h1, 2);
      access(1, 0, 32'h104, 32'd0, 3'b010, 4'h2, 2);
      access(1, 0, 32'h100, 32'd0, 3'b000, 4'h3, 2);
      access(0, 1, 32'h108, 32'h55, 3'b010, 4'h4, 2);
      idle(1);
      check("perf_hits", hit_count, 32'd3);
      check("perf_misses", miss_count, 32'd1);
`endif

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
